// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit and the control unit that
// drives it: command encoding, FSM state encoding, widths and a helper.
package mult_div_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 6;
  localparam int ITERATIONS = DATA_WIDTH;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_MULT = 2'b01;
  localparam logic [1:0] CMD_DIV  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter value seen on the final iteration edge.
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITERATIONS - 1);

  // Unsigned magnitude of a two's-complement value; the most negative value
  // maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Command/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
//
// Handshake: the master raises mult_div to a nonzero command with a/b valid and
// holds it; the slave samples a/b on the accepting edge only, raises done when
// hi/lo/div0 are final and keeps done high until it sees mult_div == 00. The
// master drops mult_div to 00 after seeing done; a still-held command never
// restarts the unit. dbg_state mirrors the FSM state for observation.
interface mult_div_if;
  import mult_div_pkg::*;

  logic [1:0]            mult_div;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic                  div0;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  state_e                dbg_state;

  modport master (
    output mult_div, a, b,
    input  busy, done, div0, hi, lo, dbg_state
  );

  modport slave (
    input  mult_div, a, b,
    output busy, done, div0, hi, lo, dbg_state
  );

endinterface

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration on the accumulator {P_hi, P_lo, q-1}.
// P_hi carries one guard bit (33 bits) so that adding or subtracting the
// most negative multiplicand can never wrap before the arithmetic shift.
module booth_step
  import mult_div_pkg::*;
(
  input  logic [2*DATA_WIDTH+1:0] i_acc,
  input  logic [DATA_WIDTH-1:0]   i_m,
  output logic [2*DATA_WIDTH+1:0] o_acc
);

  logic [DATA_WIDTH:0] w_m_ext;
  logic [DATA_WIDTH:0] w_hi;
  logic [DATA_WIDTH:0] w_sum;

  assign w_m_ext = {i_m[DATA_WIDTH-1], i_m};
  assign w_hi    = i_acc[2*DATA_WIDTH+1:DATA_WIDTH+1];

  // Booth recoding on {q0, q-1}: 01 adds M, 10 subtracts M, else no change.
  always_comb begin
    w_sum = w_hi;
    case (i_acc[1:0])
      2'b01:   w_sum = w_hi + w_m_ext;
      2'b10:   w_sum = w_hi - w_m_ext;
      default: w_sum = w_hi;
    endcase
  end

  // Arithmetic shift right by one; the old q-1 falls off the bottom.
  assign o_acc = {w_sum[DATA_WIDTH], w_sum, i_acc[DATA_WIDTH:1]};

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) unit producing
// hi/lo for the mfhi/mflo path. Each accepted operation takes 32 iteration
// edges; a divide by zero finishes immediately with div0 set.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  mult_div_if.slave   bus
);

  localparam int AW = 2 * DATA_WIDTH + 2;

  state_e                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_div0;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [AW-1:0]         r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_dq;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic                  r_neg_q;
  logic                  r_neg_r;

  logic [AW-1:0]         w_acc_next;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_dq_next;

  booth_step u_booth (
    .i_acc (r_acc),
    .i_m   (r_mcand),
    .o_acc (w_acc_next)
  );

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the difference only when it does not go negative.
  always_comb begin
    w_shift    = {r_rem, r_dq[DATA_WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_dvs};
    w_qbit     = ~w_trial[DATA_WIDTH];
    w_rem_next = w_qbit ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    w_dq_next  = {r_dq[DATA_WIDTH-2:0], w_qbit};
  end

  // Control FSM with registered busy/done/div0 and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_rem   <= '0;
      r_dq    <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mult_div == CMD_MULT) begin
            r_cnt   <= '0;
            r_div0  <= 1'b0;
            r_mcand <= bus.a;
            r_acc   <= {{(DATA_WIDTH+1){1'b0}}, bus.b, 1'b0};
            r_busy  <= 1'b1;
            r_state <= ST_MULT;
          end else if (bus.mult_div == CMD_DIV) begin
            r_cnt <= '0;
            if (bus.b == '0) begin
              // Nothing to iterate: report immediately, leave hi/lo alone.
              r_div0  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_div0  <= 1'b0;
              r_rem   <= '0;
              r_dq    <= magnitude(bus.a);
              r_dvs   <= magnitude(bus.b);
              r_neg_q <= bus.a[DATA_WIDTH-1] ^ bus.b[DATA_WIDTH-1];
              r_neg_r <= bus.a[DATA_WIDTH-1];
              r_busy  <= 1'b1;
              r_state <= ST_DIV;
            end
          end
        end
        ST_MULT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_hi    <= w_acc_next[2*DATA_WIDTH:DATA_WIDTH+1];
            r_lo    <= w_acc_next[DATA_WIDTH:1];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_next;
          r_dq  <= w_dq_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            // Truncating division: quotient sign from a^b, remainder from a.
            r_lo    <= r_neg_q ? (~w_dq_next + 1'b1) : w_dq_next;
            r_hi    <= r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Wait for the command to drop so a held command cannot retrigger.
          if (bus.mult_div == CMD_NONE) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.div0      = r_div0;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule
